// File: rtl/snn_pkg.sv
// Shared codes and defaults for the SNN evaluation-window controller.
package snn_pkg;

    localparam int DEF_N_STEPS          = 64;
    localparam int DEF_LY2_DELAY        = 1;
    localparam int DEF_N_SP_TO_ACTIVATE = 5;
    localparam int DEF_CNT_W            = 8;

    typedef logic [1:0] class_t;

    localparam class_t CLS_NONE   = 2'd0;
    localparam class_t CLS_BLUE   = 2'd1;
    localparam class_t CLS_YELLOW = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DECIDE = 3'd4
    } state_t;

endpackage

// File: rtl/spike_counter.sv
// Saturating spike counter with synchronous clear and count enable.
module spike_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/snn_window_ctrl.sv
// Per-pixel SNN window sequencer: neuron resets, step index, output-spike
// counting and a registered classification with a one-cycle valid pulse.
module snn_window_ctrl
    import snn_pkg::*;
#(
    parameter int N_STEPS          = DEF_N_STEPS,
    parameter int LY2_DELAY        = DEF_LY2_DELAY,
    parameter int N_SP_TO_ACTIVATE = DEF_N_SP_TO_ACTIVATE,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       out0_sp,
    input  logic       out1_sp,
    output logic       res_ly_1,
    output logic       res_ly_2,
    output logic [7:0] step,
    output logic       pix_ack,
    output logic       busy,
    output logic       class_valid,
    output logic [1:0] class_id
);

    if (N_STEPS < 1 || N_STEPS > 256) begin : g_bad_n_steps
        $error("snn_window_ctrl: N_STEPS must be within 1..256");
    end
    if (LY2_DELAY < 0 || LY2_DELAY > 15) begin : g_bad_ly2_delay
        $error("snn_window_ctrl: LY2_DELAY must be within 0..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("snn_window_ctrl: CNT_W must be at least 1");
    end

    localparam logic [7:0] STEP_LAST  = 8'(N_STEPS - 1);
    localparam logic [3:0] DRAIN_LAST = 4'((LY2_DELAY == 0) ? 0 : LY2_DELAY - 1);

    state_t           state, state_nxt;
    logic [3:0]       drain_cnt, drain_cnt_nxt;
    logic             res1_nxt, res2_nxt, ack_nxt, busy_nxt, valid_nxt;
    logic [7:0]       step_nxt;
    class_t           class_nxt;
    logic [CNT_W-1:0] count0, count1;
    logic             counting;

    // Spikes are counted in RUN and DRAIN only; the DECIDE cycle is excluded.
    assign counting = (state == S_RUN) || (state == S_DRAIN);

    spike_counter #(.W(CNT_W)) u_count0 (
        .clk   (clk),
        .reset (reset),
        .clear (state == S_CLR),
        .en    (counting && out0_sp),
        .count (count0)
    );

    spike_counter #(.W(CNT_W)) u_count1 (
        .clk   (clk),
        .reset (reset),
        .clear (state == S_CLR),
        .en    (counting && out1_sp),
        .count (count1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            drain_cnt   <= 4'd0;
            res_ly_1    <= 1'b1;
            res_ly_2    <= 1'b1;
            step        <= 8'd0;
            pix_ack     <= 1'b0;
            busy        <= 1'b0;
            class_valid <= 1'b0;
            class_id    <= CLS_NONE;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            res_ly_1    <= res1_nxt;
            res_ly_2    <= res2_nxt;
            step        <= step_nxt;
            pix_ack     <= ack_nxt;
            busy        <= busy_nxt;
            class_valid <= valid_nxt;
            class_id    <= class_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = (state == S_DRAIN) ? drain_cnt + 4'd1 : 4'd0;
        unique case (state)
            S_IDLE:   if (run) state_nxt = S_CLR;
            S_CLR:    state_nxt = S_RUN;
            S_RUN:    if (step == STEP_LAST) state_nxt = (LY2_DELAY == 0) ? S_DECIDE : S_DRAIN;
            S_DRAIN:  if (drain_cnt == DRAIN_LAST) state_nxt = S_DECIDE;
            S_DECIDE: state_nxt = run ? S_CLR : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        res1_nxt  = 1'b1;
        res2_nxt  = 1'b1;
        ack_nxt   = 1'b0;
        busy_nxt  = 1'b1;
        step_nxt  = 8'd0;
        valid_nxt = (state == S_DECIDE);
        class_nxt = class_id;
        unique case (state_nxt)
            S_IDLE:  busy_nxt = 1'b0;
            S_CLR:   ack_nxt  = 1'b1;
            S_RUN: begin
                res1_nxt = 1'b0;
                res2_nxt = 1'b0;
                step_nxt = (state == S_RUN) ? step + 8'd1 : 8'd0;
            end
            S_DRAIN: res2_nxt = 1'b0;
            default: ;
        endcase
        if (state == S_DECIDE) begin
            if (int'(count0) >= N_SP_TO_ACTIVATE) begin
                class_nxt = CLS_BLUE;
            end else if (int'(count1) >= N_SP_TO_ACTIVATE) begin
                class_nxt = CLS_YELLOW;
            end else begin
                class_nxt = CLS_NONE;
            end
        end
    end

endmodule

// File: tb/tb_snn_window_ctrl.sv
// Randomized self-checking bench for snn_window_ctrl against a window-position model.
module tb_snn_window_ctrl;

    localparam int N_STEPS   = 16;
    localparam int LY2_DELAY = 1;
    localparam int THRESH    = 5;
    localparam int CNT_MAX   = 255;
    localparam int WIN_LEN   = N_STEPS + LY2_DELAY + 2;
    localparam int SAT_STEPS = 256;

    logic       clk = 1'b0;
    logic       reset, run, out0_sp, out1_sp;
    logic       res_ly_1, res_ly_2, pix_ack, busy, class_valid;
    logic [7:0] step;
    logic [1:0] class_id;

    logic       run_s, sp0_s;
    logic       s_res1, s_res2, s_ack, s_busy, s_valid;
    logic [7:0] s_step;
    logic [1:0] s_class;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];
    bit         pending  = 1'b0;
    logic [1:0] last_cls = 2'd0;
    logic       sp0 [WIN_LEN];
    logic       sp1 [WIN_LEN];

    always #5 clk = ~clk;

    snn_window_ctrl #(
        .N_STEPS(N_STEPS), .LY2_DELAY(LY2_DELAY), .N_SP_TO_ACTIVATE(THRESH), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .out0_sp(out0_sp), .out1_sp(out1_sp),
        .res_ly_1(res_ly_1), .res_ly_2(res_ly_2), .step(step), .pix_ack(pix_ack),
        .busy(busy), .class_valid(class_valid), .class_id(class_id)
    );

    snn_window_ctrl #(
        .N_STEPS(SAT_STEPS), .LY2_DELAY(LY2_DELAY), .N_SP_TO_ACTIVATE(THRESH), .CNT_W(8)
    ) dut_sat (
        .clk(clk), .reset(reset), .run(run_s), .out0_sp(sp0_s), .out1_sp(1'b0),
        .res_ly_1(s_res1), .res_ly_2(s_res2), .step(s_step), .pix_ack(s_ack),
        .busy(s_busy), .class_valid(s_valid), .class_id(s_class)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_class(input int c0, input int c1);
        int s0 = (c0 > CNT_MAX) ? CNT_MAX : c0;
        int s1 = (c1 > CNT_MAX) ? CNT_MAX : c1;
        if (s0 >= THRESH) return 2'd1;
        if (s1 >= THRESH) return 2'd2;
        return 2'd0;
    endfunction

    task automatic clear_pat();
        for (int c = 0; c < WIN_LEN; c++) begin
            sp0[c] = 1'b0;
            sp1[c] = 1'b0;
        end
    endtask

    // k consecutive spikes at a random offset inside the RUN cycles (1..N_STEPS).
    task automatic place(input int which, input int k);
        int off = $urandom_range(0, N_STEPS - k);
        for (int i = 0; i < k; i++) begin
            if (which == 0) sp0[1 + off + i] = 1'b1;
            else            sp1[1 + off + i] = 1'b1;
        end
    endtask

    task automatic check_idle_cycle(input string tag);
        check_eq({tag, " class_valid"}, 32'(class_valid), 32'(pending));
        if (pending) begin
            last_cls = exp_q.pop_front();
            pending  = 1'b0;
        end
        check_eq({tag, " class_id"}, 32'(class_id), 32'(last_cls));
        check_eq({tag, " busy"}, 32'(busy), 0);
        check_eq({tag, " res_ly_1"}, 32'(res_ly_1), 1);
        check_eq({tag, " res_ly_2"}, 32'(res_ly_2), 1);
        check_eq({tag, " step"}, 32'(step), 0);
        check_eq({tag, " pix_ack"}, 32'(pix_ack), 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle_cycle("idle");
            run = 1'b0; out0_sp = 1'b0; out1_sp = 1'b0;
        end
    endtask

    // Window position c: 0 = clear, 1..N_STEPS = integrate, then drain, then decide.
    task automatic do_window(input bit chained, input bit next_run);
        int  c0 = 0, c1 = 0;
        bit  run_cyc;
        if (!chained) begin
            run = 1'b1; out0_sp = 1'b0; out1_sp = 1'b0;
        end
        for (int c = 0; c < WIN_LEN; c++) begin
            @(negedge clk);
            run_cyc = (c >= 1) && (c <= N_STEPS);
            if (c == 0) begin
                check_eq($sformatf("w c%0d class_valid", c), 32'(class_valid), 32'(pending));
                if (pending) begin
                    last_cls = exp_q.pop_front();
                    pending  = 1'b0;
                end
            end else begin
                check_eq($sformatf("w c%0d class_valid", c), 32'(class_valid), 0);
            end
            check_eq($sformatf("w c%0d class_id", c), 32'(class_id), 32'(last_cls));
            check_eq($sformatf("w c%0d pix_ack", c), 32'(pix_ack), 32'(c == 0));
            check_eq($sformatf("w c%0d busy", c), 32'(busy), 1);
            check_eq($sformatf("w c%0d step", c), 32'(step), run_cyc ? c - 1 : 0);
            check_eq($sformatf("w c%0d res_ly_1", c), 32'(res_ly_1), 32'(!run_cyc));
            check_eq($sformatf("w c%0d res_ly_2", c), 32'(res_ly_2),
                     32'(!((c >= 1) && (c <= N_STEPS + LY2_DELAY))));
            run     = (c == WIN_LEN - 1) ? next_run : 1'($urandom_range(0, 1));
            out0_sp = sp0[c];
            out1_sp = sp1[c];
        end
        for (int c = 1; c <= N_STEPS + LY2_DELAY; c++) begin
            c0 += int'(sp0[c]);
            c1 += int'(sp1[c]);
        end
        exp_q.push_back(exp_class(c0, c1));
        pending = 1'b1;
    endtask

    task automatic directed(input int k0, input int k1);
        clear_pat();
        place(0, k0);
        place(1, k1);
        do_window(1'b0, 1'b0);
        idle_cycles(2);
    endtask

    initial begin
        int  lat;
        bit  prev_next, nr;
        reset = 1'b1; run = 1'b0; out0_sp = 1'b0; out1_sp = 1'b0;
        run_s = 1'b0; sp0_s = 1'b0;
        clear_pat();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst res_ly_1", 32'(res_ly_1), 1);
        check_eq("rst res_ly_2", 32'(res_ly_2), 1);
        check_eq("rst step", 32'(step), 0);
        check_eq("rst class_valid", 32'(class_valid), 0);
        check_eq("rst class_id", 32'(class_id), 0);
        check_eq("rst busy", 32'(busy), 0);
        check_eq("rst pix_ack", 32'(pix_ack), 0);
        reset = 1'b0;
        idle_cycles(2);

        // Single window: six consecutive out0 spikes.
        clear_pat();
        for (int c = 3; c < 9; c++) sp0[c] = 1'b1;
        do_window(1'b0, 1'b0);
        idle_cycles(3);

        directed(4, 7);
        directed(5, 9);
        directed(4, 4);

        // Fifth out0 spike lands in the drain cycle, then in the decide cycle.
        clear_pat(); place(0, 4); sp0[N_STEPS + 1] = 1'b1;
        do_window(1'b0, 1'b0);
        idle_cycles(2);
        clear_pat(); place(0, 4); sp0[N_STEPS + 2] = 1'b1;
        do_window(1'b0, 1'b0);
        idle_cycles(2);

        // Three back-to-back windows with run held.
        for (int w = 0; w < 3; w++) begin
            clear_pat();
            place(0, $urandom_range(0, 9));
            place(1, $urandom_range(0, 9));
            do_window(w != 0, w != 2);
        end
        idle_cycles(3);

        // Random windows with random chaining and edge-cycle spikes.
        prev_next = 1'b0;
        for (int w = 0; w < 10; w++) begin
            clear_pat();
            place(0, $urandom_range(0, 9));
            place(1, $urandom_range(0, 9));
            sp0[N_STEPS + 1] = 1'($urandom_range(0, 1));
            sp1[N_STEPS + 1] = 1'($urandom_range(0, 1));
            sp0[N_STEPS + 2] = 1'($urandom_range(0, 1));
            sp1[N_STEPS + 2] = 1'($urandom_range(0, 1));
            nr = (w == 9) ? 1'b0 : 1'($urandom_range(0, 1));
            do_window(prev_next, nr);
            if (!nr) idle_cycles(2);
            prev_next = nr;
        end

        // Reset at step 7 of a window full of out0 spikes.
        clear_pat();
        run = 1'b1; out0_sp = 1'b1; out1_sp = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            run = 1'b0;
        end
        check_eq("mid step before reset", 32'(step), 7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; out0_sp = 1'b0;
        check_eq("midrst res_ly_1", 32'(res_ly_1), 1);
        check_eq("midrst res_ly_2", 32'(res_ly_2), 1);
        check_eq("midrst step", 32'(step), 0);
        check_eq("midrst busy", 32'(busy), 0);
        check_eq("midrst pix_ack", 32'(pix_ack), 0);
        check_eq("midrst class_id", 32'(class_id), 0);
        last_cls = 2'd0;
        idle_cycles(WIN_LEN + 6);

        // Saturation: 256-step window, out0 high throughout.
        run_s = 1'b1; sp0_s = 1'b1;
        lat = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            run_s = 1'b0;
            if (s_valid) begin
                lat = c;
                break;
            end
        end
        check_eq("sat latency", 32'(lat), 2 + SAT_STEPS + LY2_DELAY);
        check_eq("sat class_id", 32'(s_class), 32'(exp_class(SAT_STEPS + LY2_DELAY, 0)));
        sp0_s = 1'b0;
        @(negedge clk);
        check_eq("sat valid pulse", 32'(s_valid), 0);
        check_eq("sat class hold", 32'(s_class), 32'(exp_class(SAT_STEPS + LY2_DELAY, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_window_ctrl.md
Name: snn_window_ctrl

Overview:
- Sequences one SNN evaluation window per pixel. Drives the layer-1 and layer-2 neuron resets (res_ly_1, res_ly_2) and the step counter.
- Counts spikes from the two output neurons and issues a registered classification with a one-cycle valid pulse.
- Sits between the input-spike generator / neuron array and the RGB output mapper, replacing ad-hoc window and count logic in the top level.

Parameters:
- N_STEPS, 64, evaluation steps per window (1..256).
- LY2_DELAY, 1, extra cycles layer 2 keeps integrating after layer 1 is reset (0..15).
- N_SP_TO_ACTIVATE, 5, output-spike count needed to classify.
- CNT_W, 8, spike counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; start or continue windows
- out0_sp  in  1  spike from output neuron 0
- out1_sp  in  1  spike from output neuron 1
- res_ly_1  out  1  layer-1 neuron reset
- res_ly_2  out  1  layer-2 neuron reset
- step  out  8  current step index
- pix_ack  out  1  one-cycle pulse; upstream may present the next pixel
- busy  out  1  window in progress
- class_valid  out  1  one-cycle pulse; class_id updated
- class_id  out  2  0 = none, 1 = class0 (blue), 2 = class1 (yellow), 3 = unused

Behaviour:
- All outputs are registered. Reset is synchronous, active-high.
- Reset values:
  - state IDLE
  - res_ly_1 = 1, res_ly_2 = 1
  - step = 0
  - both spike counts 0
  - pix_ack = 0, busy = 0, class_valid = 0, class_id = 0
- FSM states: IDLE, CLR, RUN, DRAIN, DECIDE.
- IDLE:
  - res_ly_1 = res_ly_2 = 1, busy = 0.
  - run = 1 sampled → CLR.
- CLR (1 cycle):
  - res_ly_1 = res_ly_2 = 1, busy = 1, pix_ack = 1.
  - Counts cleared to 0, step = 0.
  - → RUN.
- RUN (N_STEPS cycles):
  - res_ly_1 = res_ly_2 = 0.
  - step runs 0 .. N_STEPS-1, +1 per cycle.
  - out0_sp / out1_sp each increment their own count; both may fire in the same cycle.
  - Counts saturate at 2^CNT_W-1 and never wrap.
  - At step == N_STEPS-1 → DRAIN, or → DECIDE if LY2_DELAY == 0.
- DRAIN (LY2_DELAY cycles):
  - res_ly_1 = 1, res_ly_2 = 0, step = 0.
  - Spikes still counted.
  - → DECIDE.
- DECIDE (1 cycle):
  - res_ly_1 = res_ly_2 = 1.
  - Spikes in this cycle are NOT counted.
  - Class registered at the end of the cycle:
    - count0 >= N_SP_TO_ACTIVATE → 1
    - else count1 >= N_SP_TO_ACTIVATE → 2
    - else 0
    - count0 has priority when both pass.
  - class_valid = 1 in the following cycle only.
  - run = 1 → CLR (back-to-back windows); else → IDLE.
- class_id holds its value until the next DECIDE.
- Latency: class_valid is high exactly 2+N_STEPS+LY2_DELAY cycles after the edge that sampled run = 1 in IDLE. Window period with run held high is the same value.
- run deasserted mid-window: the window completes; no abort.
- reset mid-window: reset values at the next edge; no class_valid is emitted.
- step is 0 outside RUN.
- Parameter range violations are an elaboration error.

Decomposition:
- Package snn_pkg holds:
  - class_id codes (CLS_NONE = 0, CLS_BLUE = 1, CLS_YELLOW = 2)
  - FSM state encoding
  - default values of N_STEPS, N_SP_TO_ACTIVATE, CNT_W
- One natural sub-module: spike_counter (saturating CNT_W counter with synchronous clear and enable), instantiated twice.

Test Plan:
- All tests use N_STEPS = 16, LY2_DELAY = 1, N_SP_TO_ACTIVATE = 5 unless stated.
- Reset: assert reset for 3 cycles → res_ly_1 = res_ly_2 = 1, step = 0, class_valid = 0, class_id = 0, busy = 0, pix_ack = 0.
- Single window: run pulsed 1 cycle, out0_sp high for 6 RUN cycles, out1_sp 0 → pix_ack 1 cycle after the sampling edge; class_valid high 19 cycles after; class_id = 1; step sequence 0..15 seen.
- Class select and priority:
  - count0 = 4, count1 = 7 → class_id = 2.
  - count0 = 5, count1 = 9 → class_id = 1.
  - both 4 → class_id = 0.
- Window boundary:
  - 4 spikes in RUN + 1 on out0_sp in the DRAIN cycle → class_id = 1.
  - 4 in RUN + 1 in the DECIDE cycle → class_id = 0.
- Back-to-back windows: run held high for 3 windows → pix_ack and class_valid each pulse every 19 cycles; res_ly_2 low for 17 cycles per window.
- Reset mid-window and saturation:
  - reset at step 7 → next cycle all reset values; no class_valid afterwards.
  - Separate run with N_STEPS = 256 and out0_sp always high → count0 = 255 (no wrap) and class_id = 1.
